// File: rtl/sample_packer_pkg.sv
// Constants shared by the sample packer and the SPI master FIFO side.
// State encoding, FIFO geometry and the drop counter width.
package sample_packer_pkg;

  localparam int FIFO_DEPTH = 1024;
  localparam int CNT_W      = 11;
  localparam int BLOCKSIZE  = 256;
  localparam int DROP_W     = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  typedef logic [DROP_W-1:0] drop_t;

  function automatic drop_t sat_inc(input drop_t v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sample_packer_if.sv
// Sample input strobe plus the FIFO write port.
// master = packer side, slave = ADC/FIFO side.
interface sample_packer_if #(
  parameter int SAMPLE_W = 12,
  parameter int CNT_W    = sample_packer_pkg::CNT_W
);

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic [CNT_W-1:0]    wrcnt;
  logic                fifoWr;
  logic [7:0]          wdata;

  modport master (
    input  sample_valid,
    input  sample,
    input  wrcnt,
    output fifoWr,
    output wdata
  );

  modport slave (
    output sample_valid,
    output sample,
    output wrcnt,
    input  fifoWr,
    input  wdata
  );

endinterface

// File: rtl/sample_packer_bit_accumulator.sv
// LSB-first bit accumulator: bit 0 is the oldest bit, bits at or
// above fill are kept zero so a pad only has to bump fill to 8.
module sample_packer_bit_accumulator #(
  parameter int SAMPLE_W = 12,
  parameter int AW       = SAMPLE_W + 15,
  parameter int FW       = $clog2(AW + 1)
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] push_data,
  input  logic                pop,
  input  logic                pad,
  output logic [7:0]          byte_out,
  output logic [FW-1:0]       fill,
  output logic                room_ok
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic [FW:0]   post;
  logic [AW-1:0] keep;

  always_comb begin
    post    = {1'b0, fill_q} - (pop ? (FW+1)'(8) : '0);
    room_ok = (post + (FW+1)'(SAMPLE_W)) <= (FW+1)'(AW);
    keep    = ~({AW{1'b1}} << fill_q);
    acc_d   = acc_q;
    fill_d  = post[FW-1:0];
    if (pop) begin
      acc_d = acc_q >> 8;
    end
    if (pad) begin
      acc_d  = acc_q & keep;
      fill_d = FW'(8);
    end
    // new bits land just above whatever survives this edge's pop
    if (push) begin
      acc_d  = acc_d | (AW'(push_data) << post[FW-1:0]);
      fill_d = FW'(post + (FW+1)'(SAMPLE_W));
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

  assign byte_out = acc_q[7:0];
  assign fill     = fill_q;

endmodule

// File: rtl/sample_packer.sv
// Packs ADC samples into a gap-free byte stream for the SPI FIFO,
// throttled by the FIFO fill count, with drop accounting and flush.
module sample_packer #(
  parameter int SAMPLE_W   = 12,
  parameter int FIFO_DEPTH = sample_packer_pkg::FIFO_DEPTH,
  parameter int CNT_W      = sample_packer_pkg::CNT_W,
  parameter int AW         = SAMPLE_W + 15
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   enable,
  sample_packer_if.master        bus,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  import sample_packer_pkg::*;

  localparam int FW = $clog2(AW + 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic          fifo_wr_q;
  logic          fifo_wr_d;
  logic [7:0]    wdata_q;
  logic [7:0]    wdata_d;
  logic          overflow_q;
  logic          overflow_d;
  drop_t         drop_q;
  drop_t         drop_d;

  logic [CNT_W:0] wr_sum;
  logic           fifo_room;
  logic           pop;
  logic           push;
  logic           pad;
  logic           strobe;
  logic           room_ok;
  logic [7:0]     byte_out;
  logic [FW-1:0]  fill;

  sample_packer_bit_accumulator #(
    .SAMPLE_W (SAMPLE_W),
    .AW       (AW),
    .FW       (FW)
  ) u_acc (
    .clk       (clk),
    .arstn     (arstn),
    .push      (push),
    .push_data (bus.sample),
    .pop       (pop),
    .pad       (pad),
    .byte_out  (byte_out),
    .fill      (fill),
    .room_ok   (room_ok)
  );

  // wrcnt lags fifoWr by a cycle, so the in-flight write counts too
  assign wr_sum    = {1'b0, bus.wrcnt} + {{CNT_W{1'b0}}, fifo_wr_q};
  assign fifo_room = wr_sum < (CNT_W+1)'(FIFO_DEPTH);
  assign pop       = (fill >= FW'(8)) && fifo_room;
  assign strobe    = (state_q == RUN) && enable && bus.sample_valid;
  assign push      = strobe && room_ok;
  assign pad       = (state_q == FLUSH) && (fill != '0)
                     && (fill < FW'(8));

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    fifo_wr_d  = pop;
    wdata_d    = pop ? byte_out : wdata_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = RUN;
          drop_d     = '0;
          overflow_d = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = FLUSH;
        end else if (strobe && !room_ok) begin
          drop_d     = sat_inc(drop_q);
          overflow_d = 1'b1;
        end
      end
      FLUSH: begin
        if (fill == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      fifo_wr_q  <= 1'b0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fifo_wr_q  <= fifo_wr_d;
      wdata_q    <= wdata_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.fifoWr = fifo_wr_q;
  assign bus.wdata  = wdata_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer: per-cycle vector table plus
// throttle, saturation, reset and long-stream sequences.
module tb_sample_packer;

  localparam int SW    = 12;
  localparam int CW    = 11;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        arstn;
  logic        enable;
  logic        busy;
  logic        overflow;
  logic [15:0] drop_cnt;

  sample_packer_if #(.SAMPLE_W(SW), .CNT_W(CW)) bus ();

  sample_packer #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit fifo_model = 1'b0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (bus.fifoWr === 1'b1) got.push_back(bus.wdata);
  end

  typedef struct {
    logic        en;
    logic        sv;
    logic [11:0] s;
    logic        fw;
    logic [7:0]  wd;
    logic        bz;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // one clock; outputs are stable 1ns after the edge
  task automatic cycle();
    @(posedge clk);
    #1;
    if (fifo_model && bus.fifoWr === 1'b1) bus.wrcnt = bus.wrcnt + 1'b1;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      cycle();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  function automatic logic [11:0] smp(input int k);
    int v;
    v = k * 32'h9E3 + 32'h5A;
    return v[11:0];
  endfunction

  initial begin
    logic        bits[$];
    logic [7:0]  exp_b[$];
    logic [11:0] s;
    logic [7:0]  b;

    tbl[0]  = '{1, 0, 12'h000, 0, 8'h00, 1};
    tbl[1]  = '{1, 1, 12'hABC, 0, 8'h00, 1};
    tbl[2]  = '{1, 0, 12'h000, 1, 8'hBC, 1};
    tbl[3]  = '{1, 1, 12'h123, 0, 8'hBC, 1};
    tbl[4]  = '{1, 0, 12'h000, 1, 8'h3A, 1};
    tbl[5]  = '{1, 0, 12'h000, 1, 8'h12, 1};
    tbl[6]  = '{1, 0, 12'h000, 0, 8'h12, 1};
    tbl[7]  = '{0, 0, 12'h000, 0, 8'h12, 1};
    tbl[8]  = '{0, 0, 12'h000, 0, 8'h12, 0};
    tbl[9]  = '{1, 0, 12'h000, 0, 8'h12, 1};
    tbl[10] = '{1, 1, 12'h5A7, 0, 8'h12, 1};
    tbl[11] = '{0, 1, 12'h0FF, 1, 8'hA7, 1};
    tbl[12] = '{0, 0, 12'h000, 0, 8'hA7, 1};
    tbl[13] = '{1, 0, 12'h000, 1, 8'h05, 1};
    tbl[14] = '{0, 0, 12'h000, 0, 8'h05, 0};
    tbl[15] = '{0, 0, 12'h000, 0, 8'h05, 0};

    arstn = 1'b0;
    enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    bus.wrcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifowr", 32'(bus.fifoWr), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    arstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      bus.sample_valid = tbl[i].sv;
      bus.sample = tbl[i].s;
      cycle();
      chk($sformatf("v%0d_fifowr", i), 32'(bus.fifoWr), 32'(tbl[i].fw));
      chk($sformatf("v%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].wd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'd0);
    end
    bus.sample_valid = 1'b0;

    // FIFO one byte short of full, FIFO counts its own writes
    got.delete();
    bus.wrcnt = 11'd1023;
    fifo_model = 1'b1;
    enable = 1'b1;
    cycle();
    for (int k = 0; k < 20; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample = 12'h1C5 + 12'(k);
      cycle();
    end
    bus.sample_valid = 1'b0;
    repeat (5) cycle();
    chk("full_writes", 32'(got.size()), 32'd1);
    chk("full_byte0", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'hC5);
    chk("full_drop", 32'(drop_cnt), 32'd18);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_wrcnt", 32'(bus.wrcnt), 32'd1024);
    fifo_model = 1'b0;
    bus.wrcnt = '0;
    enable = 1'b0;
    wait_idle("full_drain_idle", 50);
    chk("full_total", 32'(got.size()), 32'd3);
    chk("full_byte1", 32'(got.size() > 1 ? got[1] : 8'hxx), 32'h61);
    chk("full_byte2", 32'(got.size() > 2 ? got[2] : 8'hxx), 32'h1C);

    // 100 back-to-back strobes: strobes 5,8,..,98 find the acc full
    got.delete();
    enable = 1'b1;
    cycle();
    for (int k = 1; k <= 100; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample = smp(k);
      cycle();
    end
    bus.sample_valid = 1'b0;
    chk("burst_drop", 32'(drop_cnt), 32'd32);
    enable = 1'b0;
    wait_idle("burst_idle", 300);
    for (int k = 1; k <= 100; k++) begin
      if (!(k >= 5 && (k - 5) % 3 == 0)) begin
        s = smp(k);
        for (int j = 0; j < 12; j++) bits.push_back(s[j]);
      end
    end
    while (bits.size() >= 8) begin
      for (int j = 0; j < 8; j++) b[j] = bits.pop_front();
      exp_b.push_back(b);
    end
    chk("burst_bytes", 32'(got.size()), 32'd102);
    for (int i = 0; i < exp_b.size(); i++) begin
      chk($sformatf("burst_b%0d", i),
          32'(i < got.size() ? got[i] : 8'hxx), 32'(exp_b[i]));
    end

    // async reset with a half byte still in the accumulator
    got.delete();
    enable = 1'b1;
    cycle();
    bus.sample_valid = 1'b1;
    bus.sample = 12'hABC;
    cycle();
    bus.sample_valid = 1'b0;
    cycle();
    #6;
    arstn = 1'b0;
    #1;
    chk("arst_fifowr", 32'(bus.fifoWr), 32'd0);
    chk("arst_wdata", 32'(bus.wdata), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    cycle();
    arstn = 1'b1;
    repeat (10) cycle();
    chk("arst_writes", 32'(got.size()), 32'd1);
    chk("arst_byte", 32'(got.size() > 0 ? got[0] : 8'hxx), 32'hBC);
    chk("arst_idle", 32'(busy), 32'd0);

    // drop counter saturation with the FIFO reported full
    bus.wrcnt = 11'd1024;
    enable = 1'b1;
    cycle();
    bus.sample_valid = 1'b1;
    bus.sample = 12'h777;
    repeat (70002) cycle();
    bus.sample_valid = 1'b0;
    chk("sat_drop", 32'(drop_cnt), 32'hFFFF);
    chk("sat_ovf", 32'(overflow), 32'd1);
    enable = 1'b0;
    cycle();
    bus.wrcnt = '0;
    wait_idle("sat_drain_idle", 100);
    enable = 1'b1;
    cycle();
    chk("restart_drop", 32'(drop_cnt), 32'd0);
    chk("restart_ovf", 32'(overflow), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    wait_idle("final_idle", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
